// File: rtl/stream_mux2_if.sv
// Handshake bundle for the 2:1 stream merger: two input channels with last
// flags, and one tagged output channel.
interface stream_mux2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din0;
    logic             vld0;
    logic             last0;
    logic             rdy0;
    logic [WIDTH-1:0] din1;
    logic             vld1;
    logic             last1;
    logic             rdy1;
    logic [WIDTH-1:0] dout;
    logic             sel_out;
    logic             last_out;
    logic             vld_out;
    logic             rdy_out;

    // Environment side: sources both input channels and sinks the output.
    modport master (
        output din0, vld0, last0, din1, vld1, last1, rdy_out,
        input  rdy0, rdy1, dout, sel_out, last_out, vld_out
    );

    // Merger side.
    modport slave (
        input  din0, vld0, last0, din1, vld1, last1, rdy_out,
        output rdy0, rdy1, dout, sel_out, last_out, vld_out
    );
endinterface

// File: rtl/stream_mux2.sv
// Two-input stream merger with packet-aware round-robin arbitration and a
// single registered output stage tagged with the source channel index.
module stream_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    stream_mux2_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]       state;
    logic             rr_ptr;
    logic [WIDTH-1:0] dout_p1;
    logic             sel_p1;
    logic             last_p1;
    logic             vld_p1;
    logic             load;
    logic             gnt0;
    logic             gnt1;
    logic             xfer0;
    logic             xfer1;

    // rr_ptr holds the last channel to finish a packet; the other wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (bus.vld0 && bus.vld1) begin
                    gnt0 = rr_ptr;
                    gnt1 = !rr_ptr;
                end else begin
                    gnt0 = bus.vld0;
                    gnt1 = bus.vld1;
                end
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase
    end

    assign load     = !vld_p1 || bus.rdy_out;
    // Ready is held low throughout reset even though the output stage is empty.
    assign bus.rdy0 = load && gnt0 && !rst;
    assign bus.rdy1 = load && gnt1 && !rst;
    assign xfer0    = bus.vld0 && bus.rdy0;
    assign xfer1    = bus.vld1 && bus.rdy1;

    // Input -> output register stage (p1): control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 1'b1;
            vld_p1 <= 1'b0;
        end else begin
            if (load) begin
                vld_p1 <= xfer0 || xfer1;
            end
            if (xfer0) begin
                if (bus.last0) begin
                    state  <= IDLE;
                    rr_ptr <= 1'b0;
                end else begin
                    state  <= LOCK0;
                end
            end else if (xfer1) begin
                if (bus.last1) begin
                    state  <= IDLE;
                    rr_ptr <= 1'b1;
                end else begin
                    state  <= LOCK1;
                end
            end else if (state != LOCK0 && state != LOCK1) begin
                state <= IDLE;
            end
        end
    end

    // Input -> output register stage (p1): data, tag and last flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_p1 <= '0;
            sel_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (xfer0) begin
            dout_p1 <= bus.din0;
            sel_p1  <= 1'b0;
            last_p1 <= bus.last0;
        end else if (xfer1) begin
            dout_p1 <= bus.din1;
            sel_p1  <= 1'b1;
            last_p1 <= bus.last1;
        end
    end

    assign bus.dout     = dout_p1;
    assign bus.sel_out  = sel_p1;
    assign bus.last_out = last_p1;
    assign bus.vld_out  = vld_p1;
endmodule
